// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_if
// Brief    : Request/response bundle between the pipeline and its stall controller.
// Revision : 1.0
// ============================================================================
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_id;
  logic             ex_start;
  logic             ex_done;
  logic             flush_req;
  logic [5:0]       stall;
  logic             flush;
  logic             ex_cancel;
  logic             ex_timeout;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stallreq_id, ex_start, ex_done, flush_req,
    input  stall, flush, ex_cancel, ex_timeout, busy, stall_cnt
  );

  modport slave (
    input  stallreq_id, ex_start, ex_done, flush_req,
    output stall, flush, ex_cancel, ex_timeout, busy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Pipeline hazard/stall controller with EX watchdog and stall counter.
// Revision : 1.0
// ============================================================================
module pipe_stall_ctrl #(
  parameter int MAX_EX_CYCLES = 64,
  parameter int FLUSH_CYCLES  = 1,
  parameter int CNT_W         = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int EX_W = $clog2(MAX_EX_CYCLES) + 1;
  localparam int FL_W = $clog2(FLUSH_CYCLES) + 1;

  localparam logic [EX_W-1:0] c_EX_LAST     = EX_W'(MAX_EX_CYCLES - 1);
  localparam logic [FL_W-1:0] c_FL_LAST     = FL_W'(FLUSH_CYCLES - 1);
  localparam logic            c_MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [5:0]      c_STALL_ID    = 6'b000111;
  localparam logic [5:0]      c_STALL_EX    = 6'b001111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EX_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t           r_state;
  logic [EX_W-1:0]  r_ex_cnt;
  logic [FL_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  state_t          w_next;
  logic [EX_W-1:0] w_ex_cnt_nxt;
  logic [FL_W-1:0] w_flush_cnt_nxt;
  logic [5:0]      w_stall;
  logic            w_flush;
  logic            w_cancel;
  logic            w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ex_cnt    <= '0;
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_ex_cnt    <= w_ex_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if ((w_stall != 6'b0) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next          = r_state;
    w_ex_cnt_nxt    = r_ex_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_stall         = 6'b0;
    w_flush         = 1'b0;
    w_cancel        = 1'b0;
    w_timeout       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.flush_req) begin
          w_flush = 1'b1;
          if (c_MULTI_FLUSH) begin
            w_next          = FLUSH;
            w_flush_cnt_nxt = FL_W'(1);
          end
        end else if (bus.ex_start) begin
          // A unit that finishes in the issue cycle never needs to hold the pipe.
          if (!bus.ex_done) begin
            w_stall      = c_STALL_EX;
            w_ex_cnt_nxt = EX_W'(1);
            w_next       = EX_BUSY;
          end
        end else if (bus.stallreq_id) begin
          w_stall = c_STALL_ID;
        end
      end
      EX_BUSY: begin
        if (bus.flush_req) begin
          w_flush      = 1'b1;
          w_cancel     = 1'b1;
          w_ex_cnt_nxt = '0;
          if (c_MULTI_FLUSH) begin
            w_next          = FLUSH;
            w_flush_cnt_nxt = FL_W'(1);
          end else begin
            w_next = IDLE;
          end
        end else if (bus.ex_done) begin
          w_stall      = bus.stallreq_id ? c_STALL_ID : 6'b0;
          w_ex_cnt_nxt = '0;
          w_next       = IDLE;
        end else if (r_ex_cnt == c_EX_LAST) begin
          w_timeout    = 1'b1;
          w_cancel     = 1'b1;
          w_ex_cnt_nxt = '0;
          w_next       = IDLE;
        end else begin
          w_stall      = c_STALL_EX;
          w_ex_cnt_nxt = r_ex_cnt + EX_W'(1);
        end
      end
      FLUSH: begin
        w_flush = 1'b1;
        if (bus.flush_req) begin
          w_flush_cnt_nxt = FL_W'(1);
        end else if (r_flush_cnt == c_FL_LAST) begin
          w_flush_cnt_nxt = '0;
          w_next          = IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + FL_W'(1);
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Inputs may toggle while reset is held, so gate the combinational outputs.
  assign bus.stall      = rst ? w_stall : 6'b0;
  assign bus.flush      = rst & w_flush;
  assign bus.ex_cancel  = rst & w_cancel;
  assign bus.ex_timeout = rst & w_timeout;
  assign bus.busy       = rst & (r_state != IDLE);
  assign bus.stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Directed vector bench for pipe_stall_ctrl (two parameter sets).
// Revision : 1.0
// ============================================================================
module tb_pipe_stall_ctrl;

  localparam logic [5:0] c_NO = 6'b000000;
  localparam logic [5:0] c_ID = 6'b000111;
  localparam logic [5:0] c_EX = 6'b001111;

  typedef struct {
    logic       sreq, start, done, freq;
    logic [5:0] stall;
    logic       flush, cancel, tmo, busy;
    logic [4:0] cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t tbl0[$];
  vec_t tbl1[$];

  pipe_stall_ctrl_if #(.CNT_W(5)) bus0 ();
  pipe_stall_ctrl_if #(.CNT_W(5)) bus1 ();

  pipe_stall_ctrl #(.MAX_EX_CYCLES(8), .FLUSH_CYCLES(3), .CNT_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  pipe_stall_ctrl #(.MAX_EX_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(5)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic vec_t v(input logic s, st, d, f, input logic [5:0] stl,
                             input logic fl, ca, to, bu, input logic [4:0] cn);
    vec_t r;
    r.sreq = s; r.start = st; r.done = d; r.freq = f; r.stall = stl;
    r.flush = fl; r.cancel = ca; r.tmo = to; r.busy = bu; r.cnt = cn;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive0(input logic s, st, d, f);
    bus0.stallreq_id = s; bus0.ex_start = st; bus0.ex_done = d; bus0.flush_req = f;
  endtask

  task automatic drive1(input logic s, st, d, f);
    bus1.stallreq_id = s; bus1.ex_start = st; bus1.ex_done = d; bus1.flush_req = f;
  endtask

  // Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
  task automatic run_tbl(input int which, input string tag);
    int n;
    vec_t t;
    n = (which == 0) ? tbl0.size() : tbl1.size();
    for (int i = 0; i < n; i++) begin
      t = (which == 0) ? tbl0[i] : tbl1[i];
      @(posedge clk); #1;
      if (which == 0) drive0(t.sreq, t.start, t.done, t.freq);
      else            drive1(t.sreq, t.start, t.done, t.freq);
      @(negedge clk);
      if (which == 0) begin
        chk({tag, ".stall"},  i, 32'(bus0.stall),      32'(t.stall));
        chk({tag, ".flush"},  i, 32'(bus0.flush),      32'(t.flush));
        chk({tag, ".cancel"}, i, 32'(bus0.ex_cancel),  32'(t.cancel));
        chk({tag, ".tmo"},    i, 32'(bus0.ex_timeout), 32'(t.tmo));
        chk({tag, ".busy"},   i, 32'(bus0.busy),       32'(t.busy));
        chk({tag, ".cnt"},    i, 32'(bus0.stall_cnt),  32'(t.cnt));
      end else begin
        chk({tag, ".stall"},  i, 32'(bus1.stall),      32'(t.stall));
        chk({tag, ".flush"},  i, 32'(bus1.flush),      32'(t.flush));
        chk({tag, ".cancel"}, i, 32'(bus1.ex_cancel),  32'(t.cancel));
        chk({tag, ".tmo"},    i, 32'(bus1.ex_timeout), 32'(t.tmo));
        chk({tag, ".busy"},   i, 32'(bus1.busy),       32'(t.busy));
        chk({tag, ".cnt"},    i, 32'(bus1.stall_cnt),  32'(t.cnt));
      end
    end
    if (which == 0) drive0(0, 0, 0, 0);
    else            drive1(0, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);

    // MAX_EX_CYCLES=8, FLUSH_CYCLES=3 instance; one continuous sequence.
    //                 s  st d  f  stall  fl ca to bu cnt
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0,  0)); // 0 idle
    tbl0.push_back(v(1, 0, 0, 0, c_ID, 0, 0, 0, 0,  0)); // 1 load-use
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0,  1));
    tbl0.push_back(v(0, 1, 0, 0, c_EX, 0, 0, 0, 0,  1)); // 3 div start
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1,  2));
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1,  3));
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1,  4));
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1,  5));
    tbl0.push_back(v(0, 0, 1, 0, c_NO, 0, 0, 0, 1,  6)); // 8 div done
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0,  6));
    tbl0.push_back(v(0, 1, 0, 0, c_EX, 0, 0, 0, 0,  6)); // 10
    tbl0.push_back(v(1, 0, 1, 0, c_ID, 0, 0, 0, 1,  7)); // done + load-use
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0,  8));
    tbl0.push_back(v(0, 1, 1, 0, c_NO, 0, 0, 0, 0,  8)); // 13 single-cycle op
    tbl0.push_back(v(0, 0, 1, 0, c_NO, 0, 0, 0, 0,  8));
    tbl0.push_back(v(0, 1, 0, 0, c_EX, 0, 0, 0, 0,  8)); // 15 watchdog
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1,  9));
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1, 10));
    tbl0.push_back(v(0, 1, 0, 0, c_EX, 0, 0, 0, 1, 11)); // restart ignored
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1, 12));
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1, 13));
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1, 14));
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 0, 1, 1, 1, 15)); // 22 timeout
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0, 15));
    tbl0.push_back(v(0, 1, 0, 0, c_EX, 0, 0, 0, 0, 15)); // 24 flush in EX
    tbl0.push_back(v(0, 0, 0, 0, c_EX, 0, 0, 0, 1, 16));
    tbl0.push_back(v(0, 0, 0, 1, c_NO, 1, 1, 0, 1, 17));
    tbl0.push_back(v(1, 0, 0, 0, c_NO, 1, 0, 0, 1, 17));
    tbl0.push_back(v(1, 1, 0, 0, c_NO, 1, 0, 0, 1, 17));
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0, 17)); // 29 back in IDLE
    tbl0.push_back(v(1, 1, 0, 1, c_NO, 1, 0, 0, 0, 17)); // 30 all at once
    tbl0.push_back(v(0, 0, 1, 0, c_NO, 1, 0, 0, 1, 17));
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 1, 0, 0, 1, 17));
    tbl0.push_back(v(0, 0, 1, 0, c_NO, 0, 0, 0, 0, 17));
    tbl0.push_back(v(0, 0, 0, 1, c_NO, 1, 0, 0, 0, 17)); // 34 flush restart
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 1, 0, 0, 1, 17));
    tbl0.push_back(v(0, 0, 0, 1, c_NO, 1, 0, 0, 1, 17));
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 1, 0, 0, 1, 17));
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 1, 0, 0, 1, 17));
    tbl0.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0, 17));

    // MAX_EX_CYCLES=2, FLUSH_CYCLES=1 instance.
    tbl1.push_back(v(0, 0, 0, 1, c_NO, 1, 0, 0, 0, 0)); // single-cycle flush
    tbl1.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0, 0));
    tbl1.push_back(v(0, 1, 0, 0, c_EX, 0, 0, 0, 0, 0));
    tbl1.push_back(v(0, 0, 0, 0, c_NO, 0, 1, 1, 1, 1)); // earliest timeout
    tbl1.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0, 1));
    tbl1.push_back(v(0, 1, 0, 0, c_EX, 0, 0, 0, 0, 1));
    tbl1.push_back(v(0, 0, 0, 1, c_NO, 1, 1, 0, 1, 2)); // flush cancels EX
    tbl1.push_back(v(0, 0, 0, 0, c_NO, 0, 0, 0, 0, 2));

    // Outputs held low during reset even with requests pending.
    @(negedge clk);
    drive0(1, 1, 0, 1);
    #1;
    chk("rst.stall", 0, 32'(bus0.stall), 32'(c_NO));
    chk("rst.flush", 0, 32'(bus0.flush), 32'd0);
    chk("rst.busy",  0, 32'(bus0.busy),  32'd0);
    chk("rst.cnt",   0, 32'(bus0.stall_cnt), 32'd0);
    drive0(0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_tbl(0, "t0");
    run_tbl(1, "t1");

    // Asynchronous reset in the middle of an EX op.
    @(posedge clk); #1 drive0(0, 1, 0, 0);
    @(posedge clk); #1 drive0(0, 0, 0, 0);
    @(posedge clk); #3;
    chk("ar.pre_busy", 0, 32'(bus0.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("ar.stall", 0, 32'(bus0.stall),     32'(c_NO));
    chk("ar.busy",  0, 32'(bus0.busy),      32'd0);
    chk("ar.cancel",0, 32'(bus0.ex_cancel), 32'd0);
    chk("ar.cnt",   0, 32'(bus0.stall_cnt), 32'd0);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1 drive0(0, 0, 1, 0);
    @(negedge clk);
    chk("ar.done_stall", 0, 32'(bus0.stall), 32'(c_NO));
    chk("ar.done_busy",  0, 32'(bus0.busy),  32'd0);
    @(posedge clk); #1 drive0(0, 0, 0, 0);
    @(negedge clk);
    chk("ar.after_busy", 0, 32'(bus0.busy),      32'd0);
    chk("ar.after_cnt",  0, 32'(bus0.stall_cnt), 32'd0);

    // Counter saturates at all-ones (31 for a 5-bit counter).
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1 drive0(1, 0, 0, 0);
      @(negedge clk);
      if (k == 30) chk("sat.cnt30", k, 32'(bus0.stall_cnt), 32'd30);
      if (k == 39) begin
        chk("sat.cnt", k, 32'(bus0.stall_cnt), 32'd31);
        chk("sat.stall", k, 32'(bus0.stall), 32'(c_ID));
      end
    end
    drive0(0, 0, 0, 0);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
